// File: rtl/puf_pkg.sv
// puf_pkg: shared types, widths and helpers for the PUF challenge sequencer
package puf_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, SYNC, EVAL, FIN} state_t;
   localparam int CHAL_W = 4;
   localparam int RESP_W = 4;
   localparam logic MODE_ENROLL = 1'b0;
   localparam logic MODE_AUTH = 1'b1;
   function automatic logic [2:0] popcount(input logic [RESP_W-1:0] v);
      popcount = '0;
      for (int i = 0; i < RESP_W; i++) popcount = popcount + 3'(v[i]);
   endfunction
endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// puf_challenge_sequencer_if: controller-side request/status bundle of the sequencer
interface puf_challenge_sequencer_if #(parameter int NUM_CHAL = 16);
   localparam int MC_W = $clog2(NUM_CHAL * 4 + 1);
   logic start;
   logic mode;
   logic busy;
   logic done;
   logic enrolled;
   logic auth_pass;
   logic auth_err;
   logic [MC_W-1:0] mismatch_count;
   modport master (output start, mode, input busy, done, enrolled, auth_pass, auth_err, mismatch_count);
   modport slave (input start, mode, output busy, done, enrolled, auth_pass, auth_err, mismatch_count);
endinterface

// File: rtl/puf_challenge_sequencer_resp_sync.sv
// puf_resp_sync: two-flop synchroniser bringing the asynchronous PUF response into clk
module puf_resp_sync
   import puf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [RESP_W-1:0] d,
   output logic [RESP_W-1:0] q
);
   logic [RESP_W-1:0] meta;
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q <= '0;
      end else begin
         meta <= d;
         q <= meta;
      end
   end
endmodule

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: sweeps RO-PUF challenge pairs, enrolls responses or scores them by Hamming distance
module puf_challenge_sequencer
   import puf_pkg::*;
#(
   parameter int NUM_CHAL = 16,
   parameter int CLEAR_CYCLES = 4,
   parameter int MEASURE_CYCLES = 1024,
   parameter logic [CHAL_W-1:0] XOR_MASK = 4'hA,
   parameter int THRESHOLD = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   puf_challenge_sequencer_if.slave ctl,
   output logic                 puf_reset,
   output logic [CHAL_W-1:0]    cha0,
   output logic [CHAL_W-1:0]    cha1,
   input  logic [RESP_W-1:0]    response
);
   localparam int MC_W = $clog2(NUM_CHAL * 4 + 1);
   localparam int IDX_W = NUM_CHAL > 1 ? $clog2(NUM_CHAL) : 1;
   localparam int MAX_PH = CLEAR_CYCLES > MEASURE_CYCLES ? CLEAR_CYCLES : MEASURE_CYCLES;
   localparam int PH_W = $clog2(MAX_PH + 2);
   state_t state;
   logic mode_r;
   logic busy;
   logic done;
   logic enrolled;
   logic auth_pass;
   logic auth_err;
   logic [MC_W-1:0] mismatch_count;
   logic [MC_W-1:0] acc;
   logic [MC_W:0] acc_sum;
   logic [MC_W-1:0] acc_sat;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_n;
   logic [PH_W-1:0] ph;
   logic [RESP_W-1:0] resp_s;
   logic [RESP_W-1:0] store [NUM_CHAL];
   logic last_idx;
   puf_resp_sync u_sync (.clk(clk), .reset(reset), .d(response), .q(resp_s));
   assign idx_n = idx + 1'b1;
   assign last_idx = idx == IDX_W'(NUM_CHAL - 1);
   assign acc_sum = {1'b0, acc} + (MC_W + 1)'(popcount(resp_s ^ store[idx]));
   assign acc_sat = acc_sum[MC_W] ? '1 : acc_sum[MC_W-1:0];
   assign ctl.busy = busy;
   assign ctl.done = done;
   assign ctl.enrolled = enrolled;
   assign ctl.auth_pass = auth_pass;
   assign ctl.auth_err = auth_err;
   assign ctl.mismatch_count = mismatch_count;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mode_r <= MODE_ENROLL;
         puf_reset <= 1'b1;
         cha0 <= '0;
         cha1 <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         enrolled <= 1'b0;
         auth_pass <= 1'b0;
         auth_err <= 1'b0;
         mismatch_count <= '0;
         acc <= '0;
         idx <= '0;
         ph <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (ctl.start) begin
               mode_r <= ctl.mode;
               idx <= '0;
               ph <= '0;
               acc <= '0;
               cha0 <= '0;
               cha1 <= XOR_MASK;
               busy <= 1'b1;
               if (ctl.mode == MODE_ENROLL) enrolled <= 1'b0;
               state <= (ctl.mode == MODE_AUTH && !enrolled) ? FIN : CLEAR;
            end
            CLEAR: if (ph == PH_W'(CLEAR_CYCLES - 1)) begin
               ph <= '0;
               puf_reset <= 1'b0;
               state <= MEASURE;
            end else ph <= ph + 1'b1;
            MEASURE: if (ph == PH_W'(MEASURE_CYCLES - 1)) begin
               ph <= '0;
               puf_reset <= 1'b1;
               state <= SYNC;
            end else ph <= ph + 1'b1;
            SYNC: if (ph == PH_W'(1)) begin
               ph <= '0;
               state <= EVAL;
            end else ph <= ph + 1'b1;
            EVAL: begin
               if (mode_r == MODE_AUTH) acc <= acc_sat;
               if (last_idx) state <= FIN;
               else begin
                  idx <= idx_n;
                  cha0 <= CHAL_W'(idx_n);
                  cha1 <= CHAL_W'(idx_n) ^ XOR_MASK;
                  state <= CLEAR;
               end
            end
            FIN: begin
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
               if (mode_r == MODE_AUTH) begin
                  mismatch_count <= acc;
                  auth_pass <= enrolled && (32'(acc) <= THRESHOLD);
                  auth_err <= !enrolled;
               end else enrolled <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // store has no reset; enrolled gates whether its contents mean anything
   always_ff @(posedge clk) begin
      if (!reset && state == EVAL && mode_r == MODE_ENROLL) store[idx] <= resp_s;
   end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb_puf_challenge_sequencer: directed table-driven checks of enroll/authenticate sweeps
module tb_puf_challenge_sequencer;
   logic clk = 1'b0;
   logic reset;
   logic puf_reset;
   logic [3:0] cha0;
   logic [3:0] cha1;
   logic [3:0] response;
   logic [3:0] seed;
   logic [3:0] flip;
   int nidx;
   int checks = 0;
   int errors = 0;
   puf_challenge_sequencer_if #(.NUM_CHAL(16)) ctl ();
   puf_challenge_sequencer #(
      .NUM_CHAL(16), .CLEAR_CYCLES(2), .MEASURE_CYCLES(8), .XOR_MASK(4'hA), .THRESHOLD(6)
   ) dut (
      .clk(clk), .reset(reset), .ctl(ctl), .puf_reset(puf_reset),
      .cha0(cha0), .cha1(cha1), .response(response)
   );
   always #5 clk = ~clk;
   assign response = (cha0 * 4'd7 + seed) ^ ((32'(cha0) < nidx) ? flip : 4'h0);
   typedef struct {
      logic m;
      logic [3:0] seed;
      logic [3:0] flip;
      int nidx;
      int mc;
      logic pass;
   } vec_t;
   vec_t v [7];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask
   task automatic sweep(input logic m, output int lat, output int lows, output int bad,
                        output logic en_mid, output logic bz);
      @(posedge clk);
      #1 ctl.start = 1'b1;
      ctl.mode = m;
      @(posedge clk);
      #1 ctl.start = 1'b0;
      lat = -1;
      lows = 0;
      bad = 0;
      bz = 1'b1;
      en_mid = ctl.enrolled;
      for (int n = 1; n <= 400 && lat < 0; n++) begin
         @(posedge clk);
         #1;
         if (!puf_reset) begin
            if (cha0 != 4'(lows / 8) || cha1 != (4'(lows / 8) ^ 4'hA)) bad++;
            lows++;
         end
         if (ctl.done) begin
            lat = n;
            bz = ctl.busy;
         end
      end
   endtask
   initial begin
      int lat, lows, bad, dn;
      logic en_mid, bz;
      v[0] = '{1'b0, 4'd3, 4'h0, 0, 0, 1'b0};
      v[1] = '{1'b1, 4'd3, 4'h0, 0, 0, 1'b1};
      v[2] = '{1'b1, 4'd3, 4'h1, 7, 7, 1'b0};
      v[3] = '{1'b1, 4'd3, 4'h2, 6, 6, 1'b1};
      v[4] = '{1'b1, 4'd3, 4'hF, 16, 64, 1'b0};
      v[5] = '{1'b0, 4'd9, 4'h0, 0, 0, 1'b0};
      v[6] = '{1'b1, 4'd9, 4'h8, 1, 1, 1'b1};
      reset = 1'b1;
      ctl.start = 1'b0;
      ctl.mode = 1'b0;
      seed = 4'd0;
      flip = 4'd0;
      nidx = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_puf_reset", puf_reset, 1);
      chk("rst_busy", ctl.busy, 0);
      chk("rst_done", ctl.done, 0);
      chk("rst_enrolled", ctl.enrolled, 0);
      chk("rst_cha0", cha0, 0);
      chk("rst_cha1", cha1, 0);
      sweep(1'b1, lat, lows, bad, en_mid, bz);
      chk("noenr_done_lat", lat >= 1 && lat <= 2, 1);
      chk("noenr_auth_err", ctl.auth_err, 1);
      chk("noenr_auth_pass", ctl.auth_pass, 0);
      chk("noenr_puf_low", lows, 0);
      for (int i = 0; i < 7; i++) begin
         seed = v[i].seed;
         flip = v[i].flip;
         nidx = v[i].nidx;
         repeat (2) @(posedge clk);
         sweep(v[i].m, lat, lows, bad, en_mid, bz);
         chk($sformatf("v%0d_done_lat", i), lat, 209);
         chk($sformatf("v%0d_busy_at_done", i), bz, 0);
         chk($sformatf("v%0d_low_cycles", i), lows, 128);
         chk($sformatf("v%0d_cha_bad", i), bad, 0);
         chk($sformatf("v%0d_enrolled_mid", i), en_mid, v[i].m);
         chk($sformatf("v%0d_enrolled", i), ctl.enrolled, 1);
         if (v[i].m) begin
            chk($sformatf("v%0d_mismatch", i), ctl.mismatch_count, v[i].mc);
            chk($sformatf("v%0d_auth_pass", i), ctl.auth_pass, v[i].pass);
            chk($sformatf("v%0d_auth_err", i), ctl.auth_err, 0);
         end
      end
      @(posedge clk);
      #1 ctl.start = 1'b1;
      ctl.mode = 1'b0;
      @(posedge clk);
      #1 ctl.start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      chk("abort_puf_low_before", puf_reset, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_puf_reset", puf_reset, 1);
      chk("abort_busy", ctl.busy, 0);
      chk("abort_enrolled", ctl.enrolled, 0);
      reset = 1'b0;
      dn = 0;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #1;
         if (ctl.done) dn++;
      end
      chk("abort_no_done", dn, 0);
      sweep(1'b1, lat, lows, bad, en_mid, bz);
      chk("abort_auth_lat", lat >= 1 && lat <= 2, 1);
      chk("abort_auth_err", ctl.auth_err, 1);
      chk("abort_auth_pass", ctl.auth_pass, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
